// File: rtl/ascon_pkg.sv
// Shared types and default widths for the Ascon job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascon_pkg;

  localparam int DEF_BLK_W  = 64;
  localparam int DEF_TAG_W  = 128;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_WDOG_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    STREAM   = 3'd2,
    WAIT_TAG = 3'd3,
    RELEASE  = 3'd4,
    ABORT    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/ascon_wdog.sv
// Idle-cycle watchdog: counts down while enabled, reloads on any activity, flags expiry at zero.
// Latency: expire is combinational from the count; reload takes effect on the next edge.
// Backpressure: none; a zero limit disables expiry entirely.
module ascon_wdog
  import ascon_pkg::*;
#(
  parameter int WDOG_W = DEF_WDOG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reload,
  input  logic              enable,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  localparam logic [WDOG_W-1:0] ONE = WDOG_W'(1);

  logic [WDOG_W-1:0] cnt;

  // Reload on activity, otherwise count down while the job is in a watched state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= limit;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  // A cycle with activity never expires, so a late handshake always wins.
  assign expire = enable && !reload && (limit != '0) && (cnt == '0);

endmodule

// File: rtl/ascon_seq.sv
// Ascon job sequencer: takes a command, streams AD then PT blocks to the core FIFOs, drains CT, captures the tag.
// Latency: command accept to LAUNCH in 1 cycle; data and CT handshakes pass straight through; done_o 1 cycle after tag.
// Backpressure: data_ready_o follows the target FIFO full flag and drops on abort; CT pops only with ct_ready_i.
module ascon_seq
  import ascon_pkg::*;
#(
  parameter int BLK_W  = DEF_BLK_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WDOG_W = DEF_WDOG_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CNT_W-1:0]  cmd_ad_blks_i,
  input  logic [CNT_W-1:0]  cmd_pt_blks_i,
  input  logic [WDOG_W-1:0] wdog_limit_i,
  input  logic              abort_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [BLK_W-1:0]  data_i,
  output logic              ct_valid_o,
  input  logic              ct_ready_i,
  output logic [BLK_W-1:0]  ct_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              core_start_o,
  input  logic              core_ready_i,
  input  logic              core_tag_valid_i,
  output logic              core_clr_o,
  output logic [CNT_W-1:0]  cfg_ad_blks_o,
  output logic [CNT_W-1:0]  cfg_pt_blks_o,
  output logic              ad_push_o,
  input  logic              ad_full_i,
  output logic              pt_push_o,
  input  logic              pt_full_i,
  output logic [BLK_W-1:0]  din_o,
  output logic              ct_pop_o,
  input  logic              ct_empty_i,
  input  logic [BLK_W-1:0]  ct_i,
  input  logic [TAG_W-1:0]  tag_i
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_t       state, state_base, state_nxt;
  logic [CNT_W-1:0] ad_rem, pt_rem, ct_cnt;
  logic             clr_second;
  logic             cmd_hs, data_hs, ad_phase, pt_open, last_pt;
  logic             wdog_reload, wdog_enable, wdog_expire;

  assign cmd_ready_o  = (state == IDLE) && core_ready_i;
  assign cmd_hs       = cmd_valid_i && cmd_ready_o;
  assign busy_o       = (state != IDLE);
  assign core_start_o = (state == LAUNCH) || (state == STREAM) || (state == WAIT_TAG);
  assign core_clr_o   = (state == ABORT);

  // AD phase lasts while fewer AD blocks than commanded have gone out; zero AD skips it.
  assign ad_phase     = (ad_rem < cfg_ad_blks_o);
  assign pt_open      = (pt_rem < cfg_pt_blks_o);
  assign data_ready_o = (state == STREAM) && !abort_i &&
                        (ad_phase ? !ad_full_i : (pt_open && !pt_full_i));
  assign data_hs      = data_valid_i && data_ready_o;
  assign ad_push_o    = data_hs && ad_phase;
  assign pt_push_o    = data_hs && !ad_phase;
  assign din_o        = data_i;
  assign last_pt      = pt_push_o && ((pt_rem + CNT_ONE) == cfg_pt_blks_o);

  assign ct_valid_o   = ((state == STREAM) || (state == WAIT_TAG)) && !ct_empty_i;
  assign ct_o         = ct_i;
  assign ct_pop_o     = ct_valid_o && ct_ready_i;

  // Next state from the protocol alone; a host abort overrides everything while a job is live.
  always_comb begin
    state_base = state;
    case (state)
      IDLE:     if (cmd_hs) state_base = LAUNCH;
      LAUNCH:   if (!core_ready_i) state_base = STREAM;
      STREAM:   if (last_pt) state_base = WAIT_TAG;
      WAIT_TAG: if (core_tag_valid_i && (ct_cnt == cfg_pt_blks_o)) state_base = RELEASE;
      RELEASE:  if (core_ready_i) state_base = IDLE;
      ABORT:    if (clr_second) state_base = IDLE;
      default:  state_base = IDLE;
    endcase
    if (abort_i && (state != IDLE) && (state != ABORT)) state_base = ABORT;
  end

  // Any state change counts as activity, so expiry can only fire in a cycle that would otherwise hold.
  assign wdog_reload = cmd_hs || data_hs || ct_pop_o || (state_base != state);
  assign wdog_enable = core_start_o;
  assign state_nxt   = wdog_expire ? ABORT : state_base;

  ascon_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .reload (wdog_reload),
    .enable (wdog_enable),
    .limit  (wdog_limit_i),
    .expire (wdog_expire)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Job bookkeeping: latched counts, progress counters, tag capture, done pulse and sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_ad_blks_o <= '0;
      cfg_pt_blks_o <= '0;
      ad_rem        <= '0;
      pt_rem        <= '0;
      ct_cnt        <= '0;
      tag_o         <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      clr_second    <= 1'b0;
    end else begin
      done_o     <= (state_nxt == RELEASE) && (state != RELEASE);
      clr_second <= (state == ABORT) && !clr_second;
      if (cmd_hs) begin
        cfg_ad_blks_o <= cmd_ad_blks_i;
        cfg_pt_blks_o <= cmd_pt_blks_i;
        ad_rem        <= '0;
        pt_rem        <= '0;
        ct_cnt        <= '0;
        err_o         <= 1'b0;
      end
      if (ad_push_o) ad_rem <= ad_rem + CNT_ONE;
      if (pt_push_o) pt_rem <= pt_rem + CNT_ONE;
      if (ct_pop_o)  ct_cnt <= ct_cnt + CNT_ONE;
      if ((state == WAIT_TAG) && (state_nxt == RELEASE)) tag_o <= tag_i;
      if ((state_nxt == ABORT) && (state != ABORT)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascon_seq.sv
// Self-checking bench for ascon_seq: a behavioural host and core surround the sequencer.
// Latency: per-cycle stimulus, outputs sampled on the falling edge.
// Backpressure: FIFO full, CT ready and host valid are driven randomly or by scenario.
module tb_ascon_seq;

  localparam int BLK_W  = 64;
  localparam int TAG_W  = 128;
  localparam int CNT_W  = 4;
  localparam int WDOG_W = 16;
  localparam logic [BLK_W-1:0] CT_KEY = 64'hA5C3_0F1E_9B7D_2468;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              cmd_valid_i, cmd_ready_o;
  logic [CNT_W-1:0]  cmd_ad_blks_i, cmd_pt_blks_i;
  logic [WDOG_W-1:0] wdog_limit_i;
  logic              abort_i, data_valid_i, data_ready_o;
  logic [BLK_W-1:0]  data_i;
  logic              ct_valid_o, ct_ready_i;
  logic [BLK_W-1:0]  ct_o;
  logic [TAG_W-1:0]  tag_o;
  logic              done_o, busy_o, err_o, core_start_o, core_ready_i, core_tag_valid_i, core_clr_o;
  logic [CNT_W-1:0]  cfg_ad_blks_o, cfg_pt_blks_o;
  logic              ad_push_o, ad_full_i, pt_push_o, pt_full_i;
  logic [BLK_W-1:0]  din_o;
  logic              ct_pop_o, ct_empty_i;
  logic [BLK_W-1:0]  ct_i;
  logic [TAG_W-1:0]  tag_i;

  always #5 clk_i = ~clk_i;

  ascon_seq #(.BLK_W(BLK_W), .TAG_W(TAG_W), .CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_ad_blks_i(cmd_ad_blks_i), .cmd_pt_blks_i(cmd_pt_blks_i),
    .wdog_limit_i(wdog_limit_i), .abort_i(abort_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .ct_o(ct_o),
    .tag_o(tag_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
    .core_start_o(core_start_o), .core_ready_i(core_ready_i),
    .core_tag_valid_i(core_tag_valid_i), .core_clr_o(core_clr_o),
    .cfg_ad_blks_o(cfg_ad_blks_o), .cfg_pt_blks_o(cfg_pt_blks_o),
    .ad_push_o(ad_push_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_full_i(pt_full_i), .din_o(din_o),
    .ct_pop_o(ct_pop_o), .ct_empty_i(ct_empty_i), .ct_i(ct_i), .tag_i(tag_i)
  );

  // Job stimulus and observation logs.
  logic [BLK_W-1:0] blocks[$];
  logic [BLK_W-1:0] ad_log[$], pt_log[$], pop_log[$];
  int ad_n, pt_n, host_idx, valid_pct, ct_rdy_pct;
  bit host_en, ct_hold, cmd_acc, last_rdy;
  int done_cnt, clr_cnt, clr_first, acc_cyc, full_viol, pops_at_done, cyc;
  int pt_full_left, pt_full_after;

  // Behavioural core: busy once started, XOR-accumulates blocks, CT = PT ^ key.
  bit core_busy;
  int core_pt;
  logic [BLK_W-1:0] core_acc;
  logic [BLK_W-1:0] ct_q[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [TAG_W-1:0] exp_tag();
    logic [BLK_W-1:0] x;
    x = '0;
    foreach (blocks[i]) x ^= blocks[i];
    return {~x, x};
  endfunction

  function automatic int ad_diff();
    int n;
    n = 0;
    if (ad_log.size() != ad_n) return 100;
    foreach (ad_log[i]) if (ad_log[i] !== blocks[i]) n++;
    return n;
  endfunction

  function automatic int pt_diff();
    int n;
    n = 0;
    if (pt_log.size() != pt_n) return 100;
    foreach (pt_log[i]) if (pt_log[i] !== blocks[ad_n + i]) n++;
    return n;
  endfunction

  function automatic int pop_diff();
    int n;
    n = 0;
    if (pop_log.size() != pt_n) return 100;
    foreach (pop_log[i]) if (pop_log[i] !== (blocks[ad_n + i] ^ CT_KEY)) n++;
    return n;
  endfunction

  task automatic drive_env();
    core_ready_i     = !core_busy;
    core_tag_valid_i = core_busy && (core_pt == pt_n);
    tag_i            = {~core_acc, core_acc};
    ct_empty_i       = (ct_q.size() == 0);
    ct_i             = (ct_q.size() == 0) ? '0 : ct_q[0];
    ad_full_i        = 1'b0;
    pt_full_i        = (pt_full_left > 0);
    ct_ready_i       = ct_hold ? core_tag_valid_i : ($urandom_range(0, 99) < ct_rdy_pct);
    data_valid_i     = host_en && (host_idx < blocks.size()) && ($urandom_range(0, 99) < valid_pct);
    data_i           = (host_idx < blocks.size()) ? blocks[host_idx] : '0;
  endtask

  task automatic cycle();
    logic [BLK_W-1:0] d;
    bit p_ad, p_pt, pop, hs, start, clr;
    @(negedge clk_i);
    p_ad = ad_push_o; p_pt = pt_push_o; pop = ct_pop_o; d = din_o;
    hs = data_valid_i && data_ready_o;
    last_rdy = data_ready_o;
    start = core_start_o; clr = core_clr_o;
    if (p_ad) ad_log.push_back(d);
    if (p_pt) pt_log.push_back(d);
    if (pop) pop_log.push_back(ct_o);
    if (done_o) begin done_cnt++; pops_at_done = pop_log.size(); end
    if (core_clr_o) begin if (clr_cnt == 0) clr_first = cyc; clr_cnt++; end
    if (pt_full_i && data_ready_o) full_viol++;
    if (cmd_valid_i && cmd_ready_o) begin cmd_acc = 1'b1; acc_cyc = cyc; end
    @(posedge clk_i);
    #1;
    cyc++;
    if (hs) host_idx++;
    if (pop && (ct_q.size() > 0)) void'(ct_q.pop_front());
    if (clr || !start) begin
      core_busy = 1'b0; core_pt = 0; core_acc = '0; ct_q.delete();
    end else begin
      core_busy = 1'b1;
      if (p_ad) core_acc ^= d;
      if (p_pt) begin core_acc ^= d; core_pt++; ct_q.push_back(d ^ CT_KEY); end
    end
    if (pt_full_left > 0) pt_full_left--;
    if ((pt_full_after > 0) && (core_pt == pt_full_after)) begin
      pt_full_left = 5; pt_full_after = -1;
    end
    if (cmd_acc) cmd_valid_i = 1'b0;
    drive_env();
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_ad_blks_i = '0; cmd_pt_blks_i = '0; wdog_limit_i = '0; abort_i = 1'b0;
    core_busy = 1'b0; core_pt = 0; core_acc = '0; ct_q.delete();
    host_en = 1'b0; ct_hold = 1'b0; valid_pct = 100; ct_rdy_pct = 100;
    pt_full_left = 0; pt_full_after = -1; blocks.delete(); host_idx = 0; pt_n = 0; ad_n = 0;
    drive_env();
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic start_job(input int ad, input int pt, input int lim);
    blocks.delete(); ad_log.delete(); pt_log.delete(); pop_log.delete();
    for (int i = 0; i < ad + pt; i++) blocks.push_back({$urandom, $urandom});
    ad_n = ad; pt_n = pt; host_idx = 0;
    done_cnt = 0; clr_cnt = 0; full_viol = 0; pops_at_done = -1; cmd_acc = 1'b0;
    cmd_ad_blks_i = CNT_W'(ad); cmd_pt_blks_i = CNT_W'(pt); wdog_limit_i = WDOG_W'(lim);
    cmd_valid_i = 1'b1;
  endtask

  task automatic run_until_done(input int budget, output bit timeout);
    int n;
    n = 0; timeout = 1'b0;
    while (!((done_cnt > 0) && !busy_o)) begin
      if (n >= budget) begin timeout = 1'b1; break; end
      cycle(); n++;
    end
  endtask

  task automatic test_reset();
    logic [10:0] ctl;
    apply_reset();
    ctl = {busy_o, done_o, err_o, core_start_o, core_clr_o, ad_push_o, pt_push_o,
           ct_pop_o, data_ready_o, ct_valid_o, cmd_ready_o};
    n_checks++;
    if (ctl !== 11'b000_0000_0001) begin
      n_errors++; $display("FAIL reset_ctrl: got %b want 00000000001", ctl);
    end
    n_checks++;
    if ({cfg_ad_blks_o, cfg_pt_blks_o} !== '0) begin
      n_errors++; $display("FAIL reset_cfg: got %h/%h want 0/0", cfg_ad_blks_o, cfg_pt_blks_o);
    end
    n_checks++;
    if (tag_o !== '0) begin n_errors++; $display("FAIL reset_tag: got %h want 0", tag_o); end
  endtask

  task automatic test_abort_idle();
    clr_cnt = 0;
    abort_i = 1'b1;
    repeat (2) cycle();
    abort_i = 1'b0;
    cycle();
    n_checks++;
    if ((busy_o !== 1'b0) || (clr_cnt != 0) || (err_o !== 1'b0)) begin
      n_errors++; $display("FAIL abort_idle: busy=%b clr=%0d err=%b want 0/0/0", busy_o, clr_cnt, err_o);
    end
  endtask

  task automatic test_basic();
    bit to;
    host_en = 1'b1; valid_pct = 100; ct_rdy_pct = 100;
    start_job(2, 3, 0);
    run_until_done(200, to);
    n_checks++;
    if (to) begin n_errors++; $display("FAIL basic_timeout: done=%0d busy=%b want done and idle", done_cnt, busy_o); end
    n_checks++;
    if (ad_diff() != 0) begin n_errors++; $display("FAIL basic_ad: got %0d pushes want 2 matching", ad_log.size()); end
    n_checks++;
    if (pt_diff() != 0) begin n_errors++; $display("FAIL basic_pt: got %0d pushes want 3 matching", pt_log.size()); end
    n_checks++;
    if (pop_diff() != 0) begin n_errors++; $display("FAIL basic_ct: got %0d pops want 3 matching", pop_log.size()); end
    n_checks++;
    if (tag_o !== exp_tag()) begin n_errors++; $display("FAIL basic_tag: got %h want %h", tag_o, exp_tag()); end
    n_checks++;
    if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
    n_checks++;
    if ((cfg_ad_blks_o !== 4'd2) || (cfg_pt_blks_o !== 4'd3)) begin
      n_errors++; $display("FAIL basic_cfg: got %0d/%0d want 2/3", cfg_ad_blks_o, cfg_pt_blks_o);
    end
  endtask

  task automatic test_no_ad();
    bit to;
    host_en = 1'b1; valid_pct = 100; ct_rdy_pct = 100;
    start_job(0, 1, 0);
    run_until_done(200, to);
    n_checks++;
    if (to || (ad_log.size() != 0) || (pt_diff() != 0)) begin
      n_errors++; $display("FAIL no_ad_stream: ad=%0d pt=%0d timeout=%0b want 0/1/0", ad_log.size(), pt_log.size(), to);
    end
    n_checks++;
    if ((done_cnt != 1) || (tag_o !== exp_tag())) begin
      n_errors++; $display("FAIL no_ad_done: done=%0d tag=%h want 1/%h", done_cnt, tag_o, exp_tag());
    end
  endtask

  task automatic test_pt_full();
    bit to;
    host_en = 1'b1; valid_pct = 100; ct_rdy_pct = 100;
    start_job(1, 4, 0);
    pt_full_after = 2;
    run_until_done(200, to);
    n_checks++;
    if (full_viol != 0) begin n_errors++; $display("FAIL pt_full_ready: got %0d ready-while-full cycles want 0", full_viol); end
    n_checks++;
    if (to || (pt_diff() != 0) || (pop_diff() != 0)) begin
      n_errors++; $display("FAIL pt_full_stream: pt=%0d ct=%0d want 4/4 matching", pt_log.size(), pop_log.size());
    end
    n_checks++;
    if (done_cnt != 1) begin n_errors++; $display("FAIL pt_full_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_ct_hold();
    bit to;
    host_en = 1'b1; valid_pct = 100; ct_hold = 1'b1;
    start_job(1, 3, 0);
    run_until_done(200, to);
    ct_hold = 1'b0;
    n_checks++;
    if (to || (pops_at_done != 3)) begin
      n_errors++; $display("FAIL ct_hold_release: pops at done=%0d want 3", pops_at_done);
    end
    n_checks++;
    if ((pop_diff() != 0) || (done_cnt != 1) || (tag_o !== exp_tag())) begin
      n_errors++; $display("FAIL ct_hold_job: pops=%0d done=%0d tag=%h want 3/1/%h", pop_log.size(), done_cnt, tag_o, exp_tag());
    end
  endtask

  task automatic test_random();
    bit to;
    host_en = 1'b1; valid_pct = 60; ct_rdy_pct = 70;
    for (int j = 0; j < 4; j++) begin
      start_job($urandom_range(0, 15), $urandom_range(1, 15), 64);
      run_until_done(600, to);
      n_checks++;
      if (to || (ad_diff() != 0) || (pt_diff() != 0) || (pop_diff() != 0)) begin
        n_errors++; $display("FAIL random_stream[%0d]: ad=%0d/%0d pt=%0d/%0d ct=%0d", j, ad_log.size(), ad_n, pt_log.size(), pt_n, pop_log.size());
      end
      n_checks++;
      if ((tag_o !== exp_tag()) || (done_cnt != 1) || (err_o !== 1'b0)) begin
        n_errors++; $display("FAIL random_tag[%0d]: tag=%h done=%0d err=%b want %h/1/0", j, tag_o, done_cnt, err_o, exp_tag());
      end
    end
    valid_pct = 100; ct_rdy_pct = 100;
  endtask

  task automatic test_watchdog();
    bit to;
    int n;
    host_en = 1'b0;
    start_job(2, 3, 8);
    n = 0;
    while (clr_cnt == 0 && n < 60) begin cycle(); n++; end
    repeat (4) cycle();
    n_checks++;
    if ((clr_cnt == 0) || ((clr_first - acc_cyc) < 9) || ((clr_first - acc_cyc) > 16)) begin
      n_errors++; $display("FAIL wdog_latency: clr=%0d after %0d cycles want abort within 9..16", clr_cnt, clr_first - acc_cyc);
    end
    n_checks++;
    if ((clr_cnt != 2) || (err_o !== 1'b1) || (busy_o !== 1'b0) || (done_cnt != 0)) begin
      n_errors++; $display("FAIL wdog_abort: clr=%0d err=%b busy=%b done=%0d want 2/1/0/0", clr_cnt, err_o, busy_o, done_cnt);
    end
    host_en = 1'b1;
    start_job(0, 1, 0);
    n = 0;
    while (!cmd_acc && n < 20) begin cycle(); n++; end
    n_checks++;
    if (!cmd_acc || (err_o !== 1'b0)) begin
      n_errors++; $display("FAIL wdog_err_clear: accepted=%0b err=%b want 1/0", cmd_acc, err_o);
    end
    run_until_done(200, to);
    n_checks++;
    if (to || (done_cnt != 1)) begin n_errors++; $display("FAIL wdog_recover: done=%0d want 1", done_cnt); end
  endtask

  task automatic test_abort_hs();
    int n, pushes;
    host_en = 1'b1; valid_pct = 100; ct_rdy_pct = 100;
    start_job(2, 3, 0);
    n = 0;
    while (ad_log.size() < 1 && n < 30) begin cycle(); n++; end
    pushes = ad_log.size() + pt_log.size();
    abort_i = 1'b1; data_valid_i = 1'b1; data_i = blocks[host_idx];
    cycle();
    abort_i = 1'b0; host_en = 1'b0; data_valid_i = 1'b0;
    n_checks++;
    if ((pushes != 1) || (last_rdy !== 1'b0) || ((ad_log.size() + pt_log.size()) != 1)) begin
      n_errors++; $display("FAIL abort_hs_push: pushes=%0d ready=%b want 1/0", ad_log.size() + pt_log.size(), last_rdy);
    end
    cycle();
    n_checks++;
    if (clr_cnt != 1) begin n_errors++; $display("FAIL abort_hs_enter: clr cycles=%0d want 1", clr_cnt); end
    repeat (4) cycle();
    n_checks++;
    if ((clr_cnt != 2) || (err_o !== 1'b1) || (busy_o !== 1'b0) || (done_cnt != 0)) begin
      n_errors++; $display("FAIL abort_hs_end: clr=%0d err=%b busy=%b done=%0d want 2/1/0/0", clr_cnt, err_o, busy_o, done_cnt);
    end
  endtask

  task automatic test_reset_midjob();
    host_en = 1'b1; valid_pct = 100;
    start_job(1, 2, 0);
    repeat (4) cycle();
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ((busy_o !== 1'b0) || (core_start_o !== 1'b0) || (done_o !== 1'b0) || (cfg_pt_blks_o !== '0)) begin
      n_errors++; $display("FAIL reset_midjob: busy=%b start=%b done=%b cfg_pt=%0d want 0/0/0/0", busy_o, core_start_o, done_o, cfg_pt_blks_o);
    end
    apply_reset();
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_abort_idle();
    test_basic();
    test_no_ad();
    test_pt_full();
    test_ct_hold();
    test_random();
    test_watchdog();
    test_abort_hs();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
